// File: rtl/datamem_pkg.sv
// Shared definitions for the data-memory AXI4 read master.
// Contents:
//   rd_state_e                   read FSM state encoding
//   SIZE_4B, BURST_INCR,
//   CACHE_MODIFIABLE_BUFFERABLE,
//   RESP_OKAY                    fixed AXI4 field values
//   word_align()                 clears the byte offset of a load address
package datamem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

  localparam logic [2:0] SIZE_4B                     = 3'b010;
  localparam logic [1:0] BURST_INCR                  = 2'b01;
  localparam logic [3:0] CACHE_MODIFIABLE_BUFFERABLE = 4'b0011;
  localparam logic [1:0] RESP_OKAY                   = 2'b00;

  // The bus only ever sees whole 32-bit words; the byte offset stays with
  // the core-side copy of the address.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/datamem_rd_rdreq_slot.sv
// One-entry buffer holding a load address that arrived while the read
// master was busy.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_addr   capture push_addr (has priority over pop)
//   pop               release the held entry
//   valid, addr       entry present / its address
module rdreq_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] push_addr,
  input  logic        pop,
  output logic        valid,
  output logic [31:0] addr
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

  // NOTE: the address is qualified by valid and could skip reset; it is
  // cleared anyway so the whole block comes out of reset in a known state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (push) begin
      addr <= push_addr;
    end
  end

endmodule

// File: rtl/datamem_rd.sv
// Read-side AXI4 master for the core's data/device memory path.
// Accepts single-word loads (RDEN/RDADDR), issues one single-beat AXI read
// at a time, and returns RDOUT/ORDADDR with a one-cycle RDVALID pulse.
// A second load arriving while busy is parked in a one-entry slot.
// Ports:
//   CLK, RSTN                     clock, asynchronous active-low reset
//   RDADDR, RDEN                  load request from the memory stage
//   ORDADDR, RDOUT, RDVALID       completed load (original byte address)
//   RDERR                         sticky bad-response flag
//   LOADING                       busy; core stalls new loads while high
//   M_AXI_AR*, M_AXI_R*           AXI4 read address / read data channels
// Build option: define DATAMEM_RD_RESP_CHECK_EN to flag RRESP != OKAY or
// RLAST == 0 on RDERR; otherwise RDERR is tied low.
module datamem_rd
  import datamem_pkg::*;
#(
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 32,
  parameter int C_M_AXI_ARUSER_WIDTH    = 1,
  parameter int C_M_AXI_RUSER_WIDTH     = 4
) (
  input  logic                               CLK,
  input  logic                               RSTN,
  input  logic [31:0]                        RDADDR,
  input  logic                               RDEN,
  output logic [31:0]                        ORDADDR,
  output logic [31:0]                        RDOUT,
  output logic                               RDVALID,
  output logic                               RDERR,
  output logic                               LOADING,
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
  output logic [7:0]                         M_AXI_ARLEN,
  output logic [2:0]                         M_AXI_ARSIZE,
  output logic [1:0]                         M_AXI_ARBURST,
  output logic                               M_AXI_ARLOCK,
  output logic [3:0]                         M_AXI_ARCACHE,
  output logic [2:0]                         M_AXI_ARPROT,
  output logic [3:0]                         M_AXI_ARQOS,
  output logic [C_M_AXI_ARUSER_WIDTH-1:0]    M_AXI_ARUSER,
  output logic                               M_AXI_ARVALID,
  input  logic                               M_AXI_ARREADY,
  input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
  input  logic [1:0]                         M_AXI_RRESP,
  input  logic                               M_AXI_RLAST,
  input  logic [C_M_AXI_RUSER_WIDTH-1:0]     M_AXI_RUSER,
  input  logic                               M_AXI_RVALID,
  output logic                               M_AXI_RREADY
);

  rd_state_e                         state_q, state_d;
  logic                              arvalid_q;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     araddr_q;
  logic [31:0]                       cur_addr_q;
  logic [31:0]                       rdout_q, ordaddr_q;
  logic                              rdvalid_q;

  logic                              ar_hs, r_hs;
  logic                              launch, slot_pop, slot_push;
  logic [31:0]                       launch_addr;
  logic                              slot_valid;
  logic [31:0]                       slot_addr;

  assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs  = M_AXI_RVALID & M_AXI_RREADY;

  // Next state and launch of a new AR. A parked request always wins over
  // a fresh RDEN so loads complete in arrival order.
  // NOTE: every signal assigned here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    launch      = 1'b0;
    slot_pop    = 1'b0;
    launch_addr = RDADDR;
    case (state_q)
      ST_IDLE: begin
        if (slot_valid) begin
          state_d     = ST_ADDR;
          launch      = 1'b1;
          slot_pop    = 1'b1;
          launch_addr = slot_addr;
        end else if (RDEN) begin
          state_d = ST_ADDR;
          launch  = 1'b1;
        end
      end
      ST_ADDR: begin
        if (ar_hs) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (r_hs) begin
          if (slot_valid) begin
            state_d     = ST_ADDR;
            launch      = 1'b1;
            slot_pop    = 1'b1;
            launch_addr = slot_addr;
          end else if (RDEN) begin
            state_d = ST_ADDR;
            launch  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Park RDEN only when it is not being launched directly; with the slot
  // already full the request is dropped (caller ignored LOADING).
  assign slot_push = RDEN & ~slot_valid & ~(launch & ~slot_pop);

  rdreq_slot u_slot (
    .clk       (CLK),
    .rst_n     (RSTN),
    .push      (slot_push),
    .push_addr (RDADDR),
    .pop       (slot_pop),
    .valid     (slot_valid),
    .addr      (slot_addr)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= ST_IDLE;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      cur_addr_q <= '0;
      rdvalid_q  <= 1'b0;
      rdout_q    <= '0;
      ordaddr_q  <= '0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= (state_d == ST_ADDR);
      rdvalid_q <= r_hs;
      // Address only changes on entry to ADDR, so it is stable for the
      // whole time ARVALID is high.
      if (launch) begin
        araddr_q   <= C_M_AXI_ADDR_WIDTH'(word_align(launch_addr));
        cur_addr_q <= launch_addr;
      end
      if (r_hs) begin
        rdout_q   <= 32'(M_AXI_RDATA);
        ordaddr_q <= cur_addr_q;
      end
    end
  end

`ifdef DATAMEM_RD_RESP_CHECK_EN
  logic rderr_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rderr_q <= 1'b0;
    end else if (r_hs && ((M_AXI_RRESP != RESP_OKAY) || !M_AXI_RLAST)) begin
      rderr_q <= 1'b1;
    end
  end

  assign RDERR = rderr_q;

  logic unused_rd_fields;
  assign unused_rd_fields = ^{M_AXI_RID, M_AXI_RUSER};
`else
  assign RDERR = 1'b0;

  logic unused_rd_fields;
  assign unused_rd_fields = ^{M_AXI_RID, M_AXI_RUSER, M_AXI_RRESP, M_AXI_RLAST};
`endif

  assign ORDADDR       = ordaddr_q;
  assign RDOUT         = rdout_q;
  assign RDVALID       = rdvalid_q;
  assign LOADING       = (state_d != ST_IDLE) | slot_valid;

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = SIZE_4B;
  assign M_AXI_ARBURST = BURST_INCR;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = CACHE_MODIFIABLE_BUFFERABLE;
  assign M_AXI_ARPROT  = 3'd0;
  assign M_AXI_ARQOS   = 4'd0;
  assign M_AXI_ARUSER  = '0;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = (state_q == ST_DATA);

endmodule
